seq_shifter: RTL and testbench

Multi-cycle, parametrised barrel-shift/rotate unit for the next datapath revision. It replaces the single-cycle combinational shifter where timing or area needs the shift spread over several clocks. It shifts by up to STEP bit positions per clock and adds rotate modes. A start/ready/done handshake lets the multi-cycle control FSM stall on it.

---
 rtl/seq_shifter.sv | 157 +++++++++++++++
 tb/tb_seq_shifter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit. The operand moves by at most STEP bit
// positions per clock, so a narrow shifter can replace a full-width barrel.
// A start/ready/done handshake lets a multi-cycle controller stall on it.
module seq_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       mode,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [2:0] OpSll = 3'b000;
    localparam logic [2:0] OpSrl = 3'b001;
    localparam logic [2:0] OpSra = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;
    localparam logic [2:0] OpRor = 3'b101;

    localparam logic [SHW-1:0] StepAmt  = SHW'(STEP);
    localparam logic [SHW:0]   WidthExt = (SHW+1)'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [SHW-1:0]   step_k;
    logic [WIDTH-1:0] step_acc;
    logic             accept;

    // True for the five codes that actually move bits; others pass through.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OpSll, OpSrl, OpSra, OpRol, OpRor: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    // One partial step of the selected operation by k positions (k < WIDTH).
    function automatic logic [WIDTH-1:0] step_op(input logic [WIDTH-1:0] a,
                                                 input logic [2:0]       op,
                                                 input logic [SHW-1:0]   k);
        logic [WIDTH-1:0] r;
        logic [SHW:0]     inv;
        // Complementary amount for the wrap-around half of a rotate; k=0
        // gives WIDTH, which shifts everything out and leaves a clean OR.
        inv = WidthExt - {1'b0, k};
        r   = a;
        case (op)
            OpSll:   r = a << k;
            OpSrl:   r = a >> k;
            OpSra:   r = WIDTH'($unsigned($signed(a) >>> k));
            OpRol:   r = (a << k) | (a >> inv);
            OpRor:   r = (a >> k) | (a << inv);
            default: r = a;
        endcase
        return r;
    endfunction

    // Move at most STEP positions this clock; never more than what remains.
    always_comb begin
        step_k   = (rem_q < StepAmt) ? rem_q : StepAmt;
        step_acc = step_op(acc_q, op_q, step_k);
    end

    // ready is a pure function of registered state, so start can be taken
    // in both IDLE and DONE (back-to-back operations).
    always_comb begin
        accept = start && (state_q != StShift);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = start ? StShift : StIdle;
            end
            StShift: begin
                state_d = (rem_q == '0) ? StDone : StShift;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    always_comb begin
        ready  = (state_q != StShift);
        done   = (state_q == StDone);
        result = result_q;
    end

    // Datapath next values: load on accept, step while shifting, publish at the end.
    always_comb begin
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result_q;
        if (accept) begin
            acc_d = data_in;
            op_d  = mode;
            // Pass-through codes skip straight to DONE on the next clock.
            rem_d = is_shift_op(mode) ? shamt : '0;
        end else if (state_q == StShift) begin
            if (rem_q == '0) begin
                result_d = acc_q;
            end else begin
                acc_d = step_acc;
                rem_d = rem_q - step_k;
            end
        end
    end

    // Datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: the driver pushes the expected result and
// completion cycle for every accepted start; the monitor checks done, ready and
// result at every falling edge.
module tb_seq_shifter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEP  = 4;
    localparam int unsigned SHW   = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic [2:0]       mode;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    seq_shifter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .mode    (mode),
        .ready   (ready),
        .done    (done),
        .result  (result)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        int               due;
    } exp_t;

    exp_t             sb_q[$];
    int               checks    = 0;
    int               failures  = 0;
    int               cycle_cnt = 0;
    logic [WIDTH-1:0] last_res  = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cycle_cnt, act, exp);
        end
    endtask

    // Reference: whole-amount shift/rotate straight from the operation definitions.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int s,
                                                   input logic [2:0] m);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            3'b000: r = d << s;
            3'b001: r = d >> s;
            3'b011: r = 32'($signed(d) >>> s);
            3'b100: for (int i = 0; i < s; i++) r = {r[WIDTH-2:0], r[WIDTH-1]};
            3'b101: for (int i = 0; i < s; i++) r = {r[0], r[WIDTH-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input int s, input logic [2:0] m);
        int l;
        if (m == 3'b000 || m == 3'b001 || m == 3'b011 || m == 3'b100 || m == 3'b101)
            l = (s + STEP - 1) / STEP + 1;
        else
            l = 1;
        return l;
    endfunction

    // Called and returns at #1 after a rising edge.
    task automatic do_op(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                         input logic [2:0] m, input logic [WIDTH-1:0] er, input int lat);
        int   waited;
        bit   ok;
        exp_t e;
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited < 64) begin
            if (ready) begin
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=ready_low expected=ready_high within 64 cycles");
            return;
        end
        start   = 1'b1;
        data_in = d;
        shamt   = s;
        mode    = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = er;
        e.due = cycle_cnt + lat;
        sb_q.push_back(e);
    endtask

    // Monitor: compare DUT against the scoreboard at every falling edge.
    always @(negedge clk) begin
        bit exp_done;
        bit exp_ready;
        if (reset) begin
            sb_q.delete();
            last_res = '0;
        end else begin
            exp_done  = (sb_q.size() > 0) && (cycle_cnt == sb_q[0].due);
            exp_ready = !((sb_q.size() > 0) && (cycle_cnt < sb_q[0].due));
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                chk("result", result, sb_q[0].res);
                last_res = sb_q[0].res;
                void'(sb_q.pop_front());
            end else begin
                chk("result_hold", result, last_res);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   s;
        logic [2:0]       m;
        int               n;

        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        mode    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_result", result, 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_ready", 32'(ready), 32'h1);
        @(posedge clk);
        #1;

        do_op(32'h0000_00F1, 5'd8,  3'b000, 32'h0000_F100, 3);
        do_op(32'h8000_0010, 5'd5,  3'b011, 32'hFC00_0000, 3);
        do_op(32'hFFFF_FFFF, 5'd31, 3'b001, 32'h0000_0001, 9);
        // Start pulses during SHIFT must be ignored.
        start   = 1'b1;
        data_in = 32'h1;
        shamt   = 5'd4;
        mode    = 3'b000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        // Issued while the previous op is still busy: lands in its DONE cycle.
        do_op(32'h0000_0001, 5'd4,  3'b000, 32'h0000_0010, 2);
        do_op(32'h0000_0001, 5'd1,  3'b101, 32'h8000_0000, 2);
        do_op(32'h8000_0001, 5'd31, 3'b100, 32'hC000_0000, 9);
        do_op(32'hDEAD_BEEF, 5'd0,  3'b001, 32'hDEAD_BEEF, 1);
        do_op(32'hDEAD_BEEF, 5'd17, 3'b110, 32'hDEAD_BEEF, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a long rotate discards it.
        do_op(32'h1234_5678, 5'd20, 3'b100, 32'h6781_2345, 6);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_result", result, 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_ready", 32'(ready), 32'h1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 150; i++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
            d = $urandom;
            s = SHW'($urandom_range(0, WIDTH - 1));
            m = 3'($urandom_range(0, 7));
            do_op(d, s, m, ref_shift(d, int'(s), m), ref_lat(int'(s), m));
        end

        n = 0;
        while (sb_q.size() > 0 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d_pending expected=0_pending", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
